// File: rtl/bsg_link_iddr_rx_unpack_if.sv
// Bundle of the PHY-side input word and the core-side valid/yumi,
// credit and error signals of the DDR receive unpacker.
interface bsg_link_iddr_rx_unpack_if #(
  parameter int width_p = 16
);
  logic [2*width_p-1:0] data_i;
  logic                 yumi_i;
  logic                 v_o;
  logic [width_p-2:0]   data_o;
  logic                 token_o;
  logic                 overflow_o;

  // The unpacker itself.
  modport slave (
    input  data_i,
    input  yumi_i,
    output v_o,
    output data_o,
    output token_o,
    output overflow_o
  );

  // The PHY and consumer side.
  modport master (
    output data_i,
    output yumi_i,
    input  v_o,
    input  data_o,
    input  token_o,
    input  overflow_o
  );
endinterface

// File: rtl/bsg_link_iddr_rx_unpack.sv
// DDR receive unpacker: splits each PHY word into its older (low) and
// younger (high) flits, keeps the valid ones in order in a small FIFO,
// hands them out with valid/yumi and returns decimated credit tokens.
module bsg_link_iddr_rx_unpack #(
  parameter int width_p                         = 16,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 1
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bsg_link_iddr_rx_unpack_if.slave link
);

  localparam int depth_lp = 1 << lg_fifo_depth_p;
  localparam int cnt_w_lp = lg_fifo_depth_p + 1;
  localparam int tok_w_lp = (lg_credit_to_token_decimation_p == 0) ? 1
                                                                   : lg_credit_to_token_decimation_p;

  typedef logic [width_p-2:0]         payload_t;
  typedef logic [lg_fifo_depth_p-1:0] ptr_t;
  typedef logic [cnt_w_lp-1:0]        cnt_t;
  typedef logic [tok_w_lp-1:0]        tok_t;

  payload_t mem_q [depth_lp];

  ptr_t     rptr_q, rptr_d;
  ptr_t     wptr_q, wptr_d;
  ptr_t     wptr_p1;
  cnt_t     count_q, count_d;
  cnt_t     free_slots;
  tok_t     tok_cnt_q, tok_cnt_d;
  logic     token_q, token_d;
  logic     ovf_q, ovf_d;

  logic     vl, vh;
  logic     pop;
  logic     wr0_en, wr1_en;
  payload_t wr0_data, wr1_data;
  logic [1:0] n_wr;

  // Decode the PHY word, decide which flits fit, and compute pointer,
  // occupancy, token and overflow updates.
  always_comb begin
    vl         = link.data_i[width_p-1];
    vh         = link.data_i[2*width_p-1];
    // Space is judged on start-of-cycle occupancy; a same-cycle pop
    // does not make room for this cycle's writes.
    free_slots = cnt_t'(depth_lp) - count_q;
    pop        = link.yumi_i & (count_q != '0);
    wptr_p1    = wptr_q + ptr_t'(1);

    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    // Slot 0 takes the older flit when present, otherwise the younger one.
    wr0_data = vl ? link.data_i[width_p-2:0] : link.data_i[2*width_p-2:width_p];
    wr1_data = link.data_i[2*width_p-2:width_p];
    n_wr     = 2'd0;
    ovf_d    = ovf_q;

    if (vl & vh) begin
      if (free_slots >= cnt_t'(2)) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
        n_wr   = 2'd2;
      end else if (free_slots == cnt_t'(1)) begin
        // Only the older flit fits; the younger one is lost.
        wr0_en = 1'b1;
        n_wr   = 2'd1;
        ovf_d  = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (vl | vh) begin
      if (free_slots != '0) begin
        wr0_en = 1'b1;
        n_wr   = 2'd1;
      end else begin
        ovf_d  = 1'b1;
      end
    end

    wptr_d  = wptr_q + ptr_t'(n_wr);
    rptr_d  = rptr_q + ptr_t'(pop);
    count_d = count_q + cnt_t'(n_wr) - cnt_t'(pop);

    if (lg_credit_to_token_decimation_p == 0) begin
      tok_cnt_d = '0;
      token_d   = pop;
    end else begin
      tok_cnt_d = tok_cnt_q + tok_t'(pop);
      token_d   = pop & (&tok_cnt_q);
    end
  end

  // Control state: pointers, occupancy, token counter and sticky overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      tok_cnt_q <= '0;
      token_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      tok_cnt_q <= tok_cnt_d;
      token_q   <= token_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; not reset, contents only matter while occupied.
  always_ff @(posedge clk_i) begin
    if (wr0_en) mem_q[wptr_q]  <= wr0_data;
    if (wr1_en) mem_q[wptr_p1] <= wr1_data;
  end

  assign link.v_o        = (count_q != '0);
  assign link.data_o     = mem_q[rptr_q];
  assign link.token_o    = token_q;
  assign link.overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_link_iddr_rx_unpack.sv
// Randomized and directed bench for the DDR receive unpacker, checked
// against a queue-based reference model.
module tb_bsg_link_iddr_rx_unpack;

  localparam int W    = 16;
  localparam int DEPTH = 8;
  localparam int TOKN  = 2;   // pops per token

  logic clk;
  logic reset_n;

  bsg_link_iddr_rx_unpack_if #(.width_p(W)) bus ();

  bsg_link_iddr_rx_unpack #(
    .width_p(W),
    .lg_fifo_depth_p(3),
    .lg_credit_to_token_decimation_p(1)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .link     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.yumi_i && !bus.v_o)) else $error("yumi_i asserted while v_o low");
    end
  end

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [14:0] mq[$];
  bit          m_ovf;
  int          m_pops;
  bit          m_tok;

  function automatic logic [15:0] flit(input logic [14:0] p);
    return {1'b1, p};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_pops = 0;
    m_tok  = 1'b0;
  endtask

  // Drive one cycle, advance the model, return #1 after the edge.
  task automatic step(input logic [31:0] d, input bit y);
    int free;
    logic [14:0] fl[$];
    free = DEPTH - mq.size();
    bus.data_i = d;
    bus.yumi_i = y;
    if (y && mq.size() != 0) begin
      void'(mq.pop_front());
      m_pops++;
      m_tok = (m_pops % TOKN) == 0;
    end else begin
      m_tok = 1'b0;
    end
    if (d[15]) fl.push_back(d[14:0]);
    if (d[31]) fl.push_back(d[30:16]);
    for (int k = 0; k < fl.size(); k++) begin
      if (k < free) mq.push_back(fl[k]);
      else          m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (bus.v_o !== 1'b0 || bus.token_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state v/tok/ovf=%b%b%b want 000", bus.v_o, bus.token_o, bus.overflow_o);
    end
    for (int i = 0; i < 10; i++) begin
      step(32'h0, 1'b0);
      nvec++;
      if ({bus.v_o, bus.token_o, bus.overflow_o} !== 3'b000) begin
        nerr++;
        $display("FAIL idle_cycle%0d v/tok/ovf=%b%b%b want 000", i, bus.v_o, bus.token_o, bus.overflow_o);
      end
    end
  endtask

  task automatic test_low_only();
    do_reset();
    step({16'h0000, 16'h8123}, 1'b0);
    nvec++;
    if (bus.v_o !== 1'b1 || bus.data_o !== 15'h0123) begin
      nerr++;
      $display("FAIL low_only v=%b data=%h want v=1 data=0123", bus.v_o, bus.data_o);
    end
    step(32'h0, bus.v_o);
    nvec++;
    if (bus.v_o !== 1'b0 || bus.token_o !== 1'b0) begin
      nerr++;
      $display("FAIL low_only_pop v=%b tok=%b want v=0 tok=0", bus.v_o, bus.token_o);
    end
  endtask

  task automatic test_double_order();
    do_reset();
    step({16'h8BBB, 16'h8AAA}, 1'b0);
    nvec++;
    if (bus.v_o !== 1'b1 || bus.data_o !== 15'h0AAA) begin
      nerr++;
      $display("FAIL double_first v=%b data=%h want v=1 data=0aaa", bus.v_o, bus.data_o);
    end
    step(32'h0, 1'b1);
    nvec++;
    if (bus.v_o !== 1'b1 || bus.data_o !== 15'h0BBB) begin
      nerr++;
      $display("FAIL double_second v=%b data=%h want v=1 data=0bbb", bus.v_o, bus.data_o);
    end
    step(32'h0, 1'b1);
    nvec++;
    if (bus.v_o !== 1'b0 || bus.token_o !== 1'b1) begin
      nerr++;
      $display("FAIL double_drained v=%b tok=%b want v=0 tok=1", bus.v_o, bus.token_o);
    end
  endtask

  task automatic test_token();
    int pulses;
    do_reset();
    step({flit(15'h0002), flit(15'h0001)}, 1'b0);
    step({flit(15'h0004), flit(15'h0003)}, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(32'h0, 1'b1);
      if (bus.token_o === 1'b1) pulses++;
      nvec++;
      if (bus.token_o !== ((i % 2) == 1) || bus.token_o !== m_tok) begin
        nerr++;
        $display("FAIL token_pop%0d tok=%b want %b", i + 1, bus.token_o, m_tok);
      end
    end
    step(32'h0, 1'b0);
    nvec++;
    if (pulses != 2 || bus.token_o !== 1'b0) begin
      nerr++;
      $display("FAIL token_total pulses=%0d tok=%b want 2 pulses, tok=0", pulses, bus.token_o);
    end
  endtask

  task automatic test_overflow();
    logic [14:0] exp [8];
    exp = '{15'h10, 15'h11, 15'h12, 15'h13, 15'h14, 15'h15, 15'h16, 15'h01};
    do_reset();
    step({flit(15'h11), flit(15'h10)}, 1'b0);
    step({flit(15'h13), flit(15'h12)}, 1'b0);
    step({flit(15'h15), flit(15'h14)}, 1'b0);
    step({16'h0000, flit(15'h16)}, 1'b0);
    nvec++;
    if (bus.overflow_o !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_before got %b want 0", bus.overflow_o);
    end
    step({16'h8002, 16'h8001}, 1'b0);
    nvec++;
    if (bus.overflow_o !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_partial got %b want 1", bus.overflow_o);
    end
    step({16'h8777, 16'h0000}, 1'b0);   // FIFO full: dropped
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (bus.v_o !== 1'b1 || bus.data_o !== exp[i]) begin
        nerr++;
        $display("FAIL ovf_drain%0d v=%b data=%h want v=1 data=%h", i, bus.v_o, bus.data_o, exp[i]);
      end
      step(32'h0, 1'b1);
    end
    nvec++;
    if (bus.v_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_after v=%b ovf=%b want v=0 ovf=1", bus.v_o, bus.overflow_o);
    end
  endtask

  task automatic test_wrap_stream();
    logic [14:0] a, b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      a = 15'($urandom);
      b = 15'($urandom);
      step({flit(b), flit(a)}, mq.size() != 0);
      nvec++;
      if (bus.v_o !== (mq.size() != 0) || bus.token_o !== m_tok || bus.overflow_o !== m_ovf ||
          (mq.size() != 0 && bus.data_o !== mq[0])) begin
        nerr++;
        $display("FAIL stream%0d v=%b data=%h tok=%b ovf=%b want v=%b data=%h tok=%b ovf=%b",
                 i, bus.v_o, bus.data_o, bus.token_o, bus.overflow_o,
                 mq.size() != 0, (mq.size() != 0) ? mq[0] : 15'h0, m_tok, m_ovf);
      end
    end
    // Asynchronous reset in the middle of the stream.
    bus.data_i = {flit(15'h55), flit(15'h44)};
    bus.yumi_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (bus.v_o !== 1'b0 || bus.token_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset v/tok/ovf=%b%b%b want 000", bus.v_o, bus.token_o, bus.overflow_o);
    end
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      step(32'h0, 1'b0);
      nvec++;
      if (bus.v_o !== 1'b0 || bus.token_o !== 1'b0) begin
        nerr++;
        $display("FAIL post_reset%0d v=%b tok=%b want 0 0", i, bus.v_o, bus.token_o);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    bit y;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      y = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      step(d, y);
      nvec++;
      if (bus.v_o !== (mq.size() != 0) || bus.token_o !== m_tok || bus.overflow_o !== m_ovf ||
          (mq.size() != 0 && bus.data_o !== mq[0])) begin
        nerr++;
        $display("FAIL random%0d v=%b data=%h tok=%b ovf=%b want v=%b data=%h tok=%b ovf=%b",
                 i, bus.v_o, bus.data_o, bus.token_o, bus.overflow_o,
                 mq.size() != 0, (mq.size() != 0) ? mq[0] : 15'h0, m_tok, m_ovf);
      end
      // Occasionally drain so the overflow-free regime is also covered.
      if (i == 150) begin
        do_reset();
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
    model_clear();
    test_reset();
    test_low_only();
    test_double_order();
    test_token();
    test_overflow();
    test_wrap_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
